// File: rtl/rbus_arb_rr_nto1.sv
// Frame-aware round-robin arbiter: shares one rbus output among N requesters,
// granting one whole frame (short = 1 word, long = LONG_LEN words) at a time,
// registering the granted stream onto the output and flagging protocol errors.
module rbus_arb_rr_nto1 #(
  parameter int unsigned N        = 4,
  parameter int unsigned LONG_LEN = 9
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    i_req,
  input  logic [N-1:0]    i_long,
  output logic [N-1:0]    i_gnt,
  input  logic [N-1:0]    i_stb,
  input  logic [N-1:0]    i_sof,
  input  logic [72*N-1:0] i_data,
  output logic            o_stb,
  output logic            o_sof,
  output logic [71:0]     o_data,
  input  logic [1:0]      o_rdy,
  output logic            ff_err
);

  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, GRANT, XFER} state_t;

  state_t        state_q;
  logic [PW-1:0] ptr_q;
  logic [PW-1:0] sel_q;
  logic          long_q;
  logic [7:0]    cnt_q;

  logic          found_d;
  logic [PW-1:0] pick_d;
  logic [N-1:0]  gnt_d;
  logic [N-1:0]  sel_mask;
  logic          sel_stb;
  logic          sel_sof;
  logic [71:0]   sel_data;
  logic          err_d;

  // Round-robin search: first eligible requester after the pointer, wrapping.
  always_comb begin
    logic [PW-1:0] idx;
    found_d = 1'b0;
    pick_d  = '0;
    idx     = '0;
    for (int unsigned i = 1; i <= N; i++) begin
      idx = PW'((32'(ptr_q) + i) % N);
      if (!found_d && i_req[idx] && o_rdy[i_long[idx]]) begin
        found_d = 1'b1;
        pick_d  = idx;
      end
    end
    gnt_d = '0;
    gnt_d[pick_d] = 1'b1;
  end

  // Select the granted lane and classify protocol violations for this cycle.
  always_comb begin
    sel_data = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (sel_q == PW'(i)) sel_data = i_data[i*72 +: 72];
    end
    sel_stb  = i_stb[sel_q];
    sel_sof  = i_sof[sel_q];
    sel_mask = '0;
    if (state_q != IDLE) sel_mask[sel_q] = 1'b1;
    err_d = (|(i_stb & ~sel_mask))
          || (state_q == GRANT && sel_stb && !sel_sof)
          || (state_q == XFER  && sel_stb &&  sel_sof);
  end

  // Arbitration FSM with registered grant, datapath and sticky error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= PW'(N - 1);
      sel_q   <= '0;
      long_q  <= 1'b0;
      cnt_q   <= '0;
      i_gnt   <= '0;
      o_stb   <= 1'b0;
      o_sof   <= 1'b0;
      o_data  <= '0;
      ff_err  <= 1'b0;
    end else begin
      o_stb <= 1'b0;
      if (err_d) ff_err <= 1'b1;
      unique case (state_q)
        IDLE: begin
          if (found_d) begin
            i_gnt   <= gnt_d;
            sel_q   <= pick_d;
            ptr_q   <= pick_d;
            long_q  <= i_long[pick_d];
            state_q <= GRANT;
          end
        end
        GRANT: begin
          if (sel_stb && sel_sof) begin
            o_stb  <= 1'b1;
            o_sof  <= 1'b1;
            o_data <= sel_data;
            cnt_q  <= long_q ? 8'(LONG_LEN - 1) : 8'd0;
            if (long_q) begin
              state_q <= XFER;
            end else begin
              state_q <= IDLE;
              i_gnt   <= '0;
            end
          end else if (!sel_stb && !i_req[sel_q]) begin
            // Requester withdrew before sending: release without error.
            state_q <= IDLE;
            i_gnt   <= '0;
          end
        end
        XFER: begin
          if (sel_stb) begin
            // A repeated sof is forwarded as a body word.
            o_stb  <= 1'b1;
            o_sof  <= 1'b0;
            o_data <= sel_data;
            cnt_q  <= cnt_q - 8'd1;
            if (cnt_q == 8'd1) begin
              state_q <= IDLE;
              i_gnt   <= '0;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rbus_arb_rr_nto1.sv
// Directed bench for rbus_arb_rr_nto1 (N=4, LONG_LEN=9).
module tb_rbus_arb_rr_nto1;

  localparam int unsigned N = 4;
  localparam int unsigned LONG_LEN = 9;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    i_req, i_long, i_gnt, i_stb, i_sof;
  logic [72*N-1:0] i_data;
  logic            o_stb, o_sof, ff_err;
  logic [71:0]     o_data;
  logic [1:0]      o_rdy;

  int checks = 0;
  int errors = 0;

  rbus_arb_rr_nto1 #(.N(N), .LONG_LEN(LONG_LEN)) dut (
    .clk(clk), .rst(rst), .i_req(i_req), .i_long(i_long), .i_gnt(i_gnt),
    .i_stb(i_stb), .i_sof(i_sof), .i_data(i_data), .o_stb(o_stb),
    .o_sof(o_sof), .o_data(o_data), .o_rdy(o_rdy), .ff_err(ff_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_word(input int k, input logic sof, input logic [71:0] d);
    i_stb[k] = 1'b1;
    i_sof[k] = sof;
    i_data[k*72 +: 72] = d;
  endtask

  task automatic clear_strobes();
    i_stb = '0;
    i_sof = '0;
  endtask

  // Header-only frame from k: grant must already be on k.
  task automatic send_short(input int k, input logic [71:0] d);
    chk("short_gnt", 72'(i_gnt), 72'(4'b0001 << k));
    drive_word(k, 1'b1, d);
    step();
    chk("short_stb", 72'(o_stb), 72'd1);
    chk("short_sof", 72'(o_sof), 72'd1);
    chk("short_data", o_data, d);
    chk("short_gnt_drop", 72'(i_gnt), 72'd0);
    clear_strobes();
  endtask

  // Long frame from k with idle gaps after words marked in gaps; word sofw
  // carries a repeated sof (use 99 for none). Drops i_req[k] on the last word.
  task automatic send_long(input int k, input logic [71:0] base,
                           input logic [8:0] gaps, input int sofw);
    int nstb = 0;
    for (int w = 0; w < 9; w++) begin
      drive_word(k, (w == 0) || (w == sofw), base + 72'(w));
      if (w == 8) i_req[k] = 1'b0;
      step();
      if (o_stb) nstb++;
      chk("long_sof", 72'(o_sof), 72'(w == 0));
      chk("long_data", o_data, base + 72'(w));
      chk("long_gnt", 72'(i_gnt), (w == 8) ? 72'd0 : 72'(4'b0001 << k));
      if (w == sofw) chk("long_rep_sof_err", 72'(ff_err), 72'd1);
      clear_strobes();
      if (gaps[w]) begin
        step();
        chk("long_gap_stb", 72'(o_stb), 72'd0);
        chk("long_gap_hold", o_data, base + 72'(w));
      end
    end
    chk("long_word_count", 72'(nstb), 72'd9);
  endtask

  initial begin
    rst = 1'b1;
    i_req = '0; i_long = '0; i_stb = '0; i_sof = '0; i_data = '0;
    o_rdy = 2'b11;
    step(); step();
    chk("rst_gnt", 72'(i_gnt), 72'd0);
    chk("rst_stb", 72'(o_stb), 72'd0);
    chk("rst_sof", 72'(o_sof), 72'd0);
    chk("rst_data", o_data, 72'd0);
    chk("rst_err", 72'(ff_err), 72'd0);

    // 1: all four short requesters, rotation 0,1,2,3,0
    rst = 1'b0;
    i_req = 4'b1111;
    step();
    send_short(0, 72'hA0);
    step();
    send_short(1, 72'hA1);
    step();
    send_short(2, 72'hA2);
    step();
    send_short(3, 72'hA3);
    step();
    send_short(0, 72'hB0);
    i_req = '0;
    step();
    chk("t1_idle_stb", 72'(o_stb), 72'd0);
    chk("t1_idle_gnt", 72'(i_gnt), 72'd0);

    // 2: long request 2 blocked by sink space, short 3 goes first
    o_rdy = 2'b01;
    i_long = 4'b0100;
    i_req = 4'b1100;
    step();
    chk("t2_gnt3", 72'(i_gnt), 72'b1000);
    send_short(3, 72'hC3);
    i_req[3] = 1'b0;
    step();
    chk("t2_blocked_a", 72'(i_gnt), 72'd0);
    step();
    chk("t2_blocked_b", 72'(i_gnt), 72'd0);
    o_rdy = 2'b11;
    step();
    chk("t2_gnt2", 72'(i_gnt), 72'b0100);

    // 3: long frame from 2 with three idle gaps
    send_long(2, 72'h200, 9'b0_1010_0100, 99);
    chk("t3_no_err", 72'(ff_err), 72'd0);

    // 4: stray strobe from 1 while 0 holds the grant
    i_long = '0;
    i_req = 4'b0001;
    step();
    chk("t4_gnt0", 72'(i_gnt), 72'b0001);
    drive_word(0, 1'b1, 72'hD0);
    drive_word(1, 1'b1, 72'hBAD);
    step();
    chk("t4_stb", 72'(o_stb), 72'd1);
    chk("t4_data_intact", o_data, 72'hD0);
    chk("t4_err_set", 72'(ff_err), 72'd1);
    clear_strobes();
    i_req = '0;
    step();
    chk("t4_err_sticky", 72'(ff_err), 72'd1);
    chk("t4_no_stray_out", 72'(o_stb), 72'd0);

    // reset clears the sticky flag
    rst = 1'b1;
    #1;
    chk("t4_rst_err", 72'(ff_err), 72'd0);
    step();
    rst = 1'b0;

    // 5: long frame from 0 with sof repeated at word 4
    i_long = 4'b0001;
    i_req = 4'b0001;
    step();
    chk("t5_gnt0", 72'(i_gnt), 72'b0001);
    chk("t5_err_clear", 72'(ff_err), 72'd0);
    send_long(0, 72'h500, 9'b0, 4);
    chk("t5_err_kept", 72'(ff_err), 72'd1);

    // 6: asynchronous reset in XFER, then arbitration restarts at 0
    rst = 1'b1;
    step();
    rst = 1'b0;
    i_long = 4'b0010;
    i_req = 4'b0010;
    step();
    chk("t6_gnt1", 72'(i_gnt), 72'b0010);
    drive_word(1, 1'b1, 72'h600);
    step();
    clear_strobes();
    drive_word(1, 1'b0, 72'h601);
    step();
    chk("t6_mid_stb", 72'(o_stb), 72'd1);
    clear_strobes();
    #2;
    rst = 1'b1;
    #1;
    chk("t6_rst_gnt", 72'(i_gnt), 72'd0);
    chk("t6_rst_stb", 72'(o_stb), 72'd0);
    chk("t6_rst_data", o_data, 72'd0);
    step();
    rst = 1'b0;
    i_long = '0;
    i_req = 4'b0011;
    step();
    chk("t6_first_gnt0", 72'(i_gnt), 72'b0001);

    // requester withdraws in GRANT without sending: release, no error
    i_req = '0;
    step();
    chk("wd_gnt", 72'(i_gnt), 72'd0);
    chk("wd_err", 72'(ff_err), 72'd0);

    // header without sof in GRANT is dropped and flagged
    i_req = 4'b0100;
    step();
    chk("nosof_gnt", 72'(i_gnt), 72'b0100);
    drive_word(2, 1'b0, 72'hEE);
    step();
    chk("nosof_drop", 72'(o_stb), 72'd0);
    chk("nosof_err", 72'(ff_err), 72'd1);
    chk("nosof_gnt_kept", 72'(i_gnt), 72'b0100);
    clear_strobes();
    i_req = '0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
